ikbd_key_sched: RTL



---
 rtl/ikbd_key_sched.sv | 61 ++++++
 1 files changed

// File: rtl/ikbd_key_sched.sv
// ikbd_key_sched: queues PS/2 key events and applies them one at a time to the IKBD key matrix,
// holding every change long enough for the ROM scan loop to see it.
module ikbd_key_sched #(
  parameter int DEPTH = 8,
  parameter int HOLD_CYCLES = 20000
) (
  input  logic                         clk,
  input  logic                         res,
  input  logic                         ev_valid,
  input  logic [6:0]                   ev_code,
  input  logic                         ev_press,
  input  logic                         flush,
  output logic [119:0]                 key_state,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
  output logic                         ev_drop,
  output logic                         busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic [6:0] hcode;
  logic hpress, pop, push, apply, drop_pend, nxt_hold;
  logic [LW-1:0] nxt_level;
  assign {hcode, hpress} = mem[rp];
  assign pop = state == IDLE && fifo_level != '0 && !flush;
  assign push = ev_valid && !flush && (fifo_level != LW'(DEPTH) || pop);
  // a popped entry only starts a hold if it is a real row and actually flips its bit
  assign apply = pop && hcode[6:3] != 4'hf && key_state[hcode] == hpress;
  assign nxt_level = flush ? '0 : fifo_level + LW'(push) - LW'(pop);
  assign nxt_hold = flush ? !(&key_state) : state == HOLD ? cnt != '0 : apply;
  always_ff @(posedge clk)
    if (push) mem[wp] <= {ev_code, ev_press};
  always_ff @(posedge clk)
    if (res) begin
      key_state <= '1;
      fifo_level <= '0;
      wp <= '0;
      rp <= '0;
      drop_pend <= 1'b0;
      ev_drop <= 1'b0;
      busy <= 1'b0;
      state <= IDLE;
      cnt <= '0;
    end else begin
      wp <= flush ? '0 : wp + AW'(push);
      rp <= flush ? '0 : rp + AW'(pop);
      fifo_level <= nxt_level;
      drop_pend <= ev_valid && !flush && !push;
      ev_drop <= drop_pend;
      state <= nxt_hold ? HOLD : IDLE;
      cnt <= flush || apply ? CW'(HOLD_CYCLES - 1) : cnt - CW'(state == HOLD && cnt != '0);
      busy <= nxt_level != '0 || nxt_hold;
      if (flush) key_state <= '1;
      else if (apply) key_state[hcode] <= ~hpress;
    end
endmodule
